// File: rtl/result_trace_pkg.sv
// Shared state encoding, default widths and entry layout for the result trace buffer.
package result_trace_pkg;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_STAMP_W = 16;
  localparam int DEF_DEPTH   = 16;
  localparam int DEF_ADDR_W  = $clog2(DEF_DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } trace_state_t;

  typedef struct packed {
    logic [DEF_DATA_W-1:0]  result;
    logic [DEF_STAMP_W-1:0] stamp;
  } trace_entry_t;

endpackage

// File: rtl/trace_fifo_ram.sv
// Register-array storage for the trace FIFO: one write port, one registered read port.
// A read that hits the address being written returns the new data (write-first).
module trace_fifo_ram #(
  parameter int WIDTH  = 48,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // NOTE: the storage array carries no reset; validity is tracked by the
  // pointers and count, so resetting it would only cost flops and routing.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= (we_i && (waddr_i == raddr_i)) ? wdata_i : mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/result_trace_buffer.sv
// Captures the datapath result bus with a cycle stamp into a FIFO drained over valid/ready.
// Build option: RESULT_TRACE_DEDUP_EN suppresses pushes that repeat the last pushed result.
module result_trace_buffer
  import result_trace_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int STAMP_W = DEF_STAMP_W,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int ADDR_W  = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DATA_W-1:0]  result,
  input  logic               result_vld,
  input  logic               capture_en,
  input  logic               clear,
  output logic [DATA_W-1:0]  out_data,
  output logic [STAMP_W-1:0] out_stamp,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ADDR_W:0]    count,
  output logic               full,
  output logic               overflow
);

  localparam int              ENTRY_W    = DATA_W + STAMP_W;
  localparam logic [ADDR_W:0] FULL_CNT   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] ALMOST_CNT = (ADDR_W + 1)'(DEPTH - 1);

  trace_state_t       state_q;
  logic [STAMP_W-1:0] stamp_q;
  logic [ADDR_W-1:0]  wr_ptr_q;
  logic [ADDR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]    count_q, count_d;
  logic               overflow_q;

  logic               dedup_ok;
  logic               at_full;
  logic               sample;
  logic               push;
  logic               pop;
  logic               drop;
  logic               rd_en;
  logic [ENTRY_W-1:0] rd_data;

  assign at_full   = (count_q == FULL_CNT);
  assign out_valid = (count_q != '0);
  assign pop       = out_valid && out_ready;

  // HOLD is the full condition of RUN: a sample is still taken when a pop frees the slot.
  assign sample = ((state_q == RUN) || (state_q == HOLD)) && result_vld && dedup_ok;
  assign push   = sample && (!at_full || pop) && !clear;
  assign drop   = sample && at_full && !pop && !clear;

`ifdef RESULT_TRACE_DEDUP_EN
  logic [DATA_W-1:0] last_q;
  logic              last_vld_q;

  assign dedup_ok = !last_vld_q || (result != last_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q     <= '0;
      last_vld_q <= 1'b0;
    end else if (clear) begin
      last_q     <= '0;
      last_vld_q <= 1'b0;
    end else if (push) begin
      last_q     <= result;
      last_vld_q <= 1'b1;
    end
  end
`else
  assign dedup_ok = 1'b1;
`endif

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    if (clear) begin
      count_d  = '0;
      rd_ptr_d = '0;
    end else begin
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
        count_d = count_q + 1'b1;
      end else if (pop && !push) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  // Reading at the next head pointer keeps out_* aligned with the head one cycle after each edge.
  assign rd_en = (count_d != '0);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stamp_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      stamp_q    <= clear ? '0 : stamp_q + 1'b1;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= clear ? 1'b0 : (overflow_q || drop);
      if (clear) begin
        wr_ptr_q <= '0;
      end else if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else if (clear) begin
      state_q <= IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (capture_en) begin
            state_q <= RUN;
          end
        end
        RUN: begin
          if (push && !pop && (count_q == ALMOST_CNT)) begin
            state_q <= HOLD;
          end else if (!capture_en) begin
            state_q <= IDLE;
          end
        end
        HOLD: begin
          if (pop && !push) begin
            state_q <= capture_en ? RUN : IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  trace_fifo_ram #(
    .WIDTH  (ENTRY_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i ({result, stamp_q}),
    .re_i    (rd_en),
    .raddr_i (rd_ptr_d),
    .rdata_o (rd_data)
  );

  assign out_data  = rd_data[ENTRY_W-1 -: DATA_W];
  assign out_stamp = rd_data[STAMP_W-1:0];
  assign count     = count_q;
  assign full      = at_full;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_result_trace_buffer.sv
// Directed self-checking bench for result_trace_buffer (honours RESULT_TRACE_DEDUP_EN).
module tb_result_trace_buffer;
  import result_trace_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [DEF_DATA_W-1:0]  result;
  logic                   result_vld;
  logic                   capture_en;
  logic                   clear;
  logic [DEF_DATA_W-1:0]  out_data;
  logic [DEF_STAMP_W-1:0] out_stamp;
  logic                   out_valid;
  logic                   out_ready;
  logic [DEF_ADDR_W:0]    count;
  logic                   full;
  logic                   overflow;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  result_trace_buffer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .result     (result),
    .result_vld (result_vld),
    .capture_en (capture_en),
    .clear      (clear),
    .out_data   (out_data),
    .out_stamp  (out_stamp),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .count      (count),
    .full       (full),
    .overflow   (overflow)
  );

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    assert (observed === expected)
      else begin
        bad++;
        $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    trace_entry_t      e;
    logic [31:0]       vals6 [6];
    logic [31:0]       exp6 [$];

    rst_n      = 1'b0;
    result     = '0;
    result_vld = 1'b0;
    capture_en = 1'b0;
    clear      = 1'b0;
    out_ready  = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_count", count, 0);
    check("rst_valid", out_valid, 0);
    check("rst_full", full, 0);
    check("rst_ovf", overflow, 0);
    check("rst_data", out_data, 0);
    check("rst_stamp", out_stamp, 0);

    // Test 1: stamp reaches 3 before the first push of 5
    rst_n = 1'b1;
    tick();
    tick();
    capture_en = 1'b1;
    result_vld = 1'b1;
    result     = 32'd5;
    tick();
    check("t1_idle_no_push", count, 0);
    tick();
    check("t1_first_valid", out_valid, 1);
    check("t1_first_data", out_data, 5);
    result = 32'd6;
    tick();
    result = 32'd7;
    tick();
    result_vld = 1'b0;
    check("t1_count", count, 3);
    check("t1_data", out_data, 5);
    check("t1_stamp", out_stamp, 3);

    // Test 2: fill to 16, two more samples dropped
    for (int i = 0; i < 13; i++) begin
      result     = 32'(100 + i);
      result_vld = 1'b1;
      tick();
    end
    check("t2_full_count", count, 16);
    check("t2_state_hold", 64'(dut.state_q), 64'(HOLD));
    check("t2_ovf_before", overflow, 0);
    result = 32'd113;
    tick();
    result = 32'd114;
    tick();
    result_vld = 1'b0;
    check("t2_ovf", overflow, 1);
    check("t2_full", full, 1);
    check("t2_count", count, 16);
    check("t2_head_held", out_data, 5);
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      e.result = 32'(i < 3 ? 5 + i : 97 + i);
      e.stamp  = 16'(3 + i);
      check("t2_drain_data", out_data, e.result);
      check("t2_drain_stamp", out_stamp, e.stamp);
      tick();
    end
    out_ready = 1'b0;
    check("t2_empty_count", count, 0);
    check("t2_empty_valid", out_valid, 0);
    check("t2_ovf_sticky", overflow, 1);

    // Test 3: push and pop together while full
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("t3_clr_ovf", overflow, 0);
    check("t3_clr_state", 64'(dut.state_q), 64'(IDLE));
    tick();
    for (int i = 0; i < 16; i++) begin
      result     = 32'(200 + i);
      result_vld = 1'b1;
      tick();
    end
    check("t3_full", full, 1);
    result    = 32'd300;
    out_ready = 1'b1;
    tick();
    result_vld = 1'b0;
    out_ready  = 1'b0;
    check("t3_count", count, 16);
    check("t3_ovf", overflow, 0);
    check("t3_head", out_data, 201);
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("t3_drain", out_data, (i < 15) ? 64'(201 + i) : 64'd300);
      tick();
    end
    out_ready = 1'b0;
    check("t3_empty", count, 0);

    // Test 6: repeated results, with or without dedup
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tick();
    vals6 = '{32'd9, 32'd9, 32'd9, 32'd4, 32'd4, 32'd9};
`ifdef RESULT_TRACE_DEDUP_EN
    exp6 = '{32'd9, 32'd4, 32'd9};
`else
    exp6 = '{32'd9, 32'd9, 32'd9, 32'd4, 32'd4, 32'd9};
`endif
    for (int i = 0; i < 6; i++) begin
      result     = vals6[i];
      result_vld = 1'b1;
      tick();
    end
    result_vld = 1'b0;
    check("t6_count", count, 64'(exp6.size()));
    out_ready = 1'b1;
    for (int i = 0; i < exp6.size(); i++) begin
      check("t6_drain", out_data, exp6[i]);
      tick();
    end
    out_ready = 1'b0;
    check("t6_empty", out_valid, 0);

    // Test 4: stamp wraps FFFF -> 0000, then clear
    clear = 1'b1;
    tick();
    clear = 1'b0;
    repeat (65535) tick();
    result     = 32'hAAAA_0001;
    result_vld = 1'b1;
    tick();
    result = 32'hAAAA_0002;
    tick();
    result_vld = 1'b0;
    check("t4_count", count, 2);
    check("t4_stamp_ffff", out_stamp, 16'hFFFF);
    check("t4_data_a", out_data, 32'hAAAA_0001);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t4_stamp_0000", out_stamp, 16'h0000);
    check("t4_data_b", out_data, 32'hAAAA_0002);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("t4_clr_count", count, 0);
    check("t4_clr_ovf", overflow, 0);
    check("t4_clr_valid", out_valid, 0);

    // Test 5: asynchronous reset while draining
    tick();
    for (int i = 1; i <= 3; i++) begin
      result     = 32'(i * 32'h11);
      result_vld = 1'b1;
      tick();
    end
    result_vld = 1'b0;
    out_ready  = 1'b1;
    tick();
    check("t5_mid_data", out_data, 32'h22);
    check("t5_mid_count", count, 2);
    #3;
    rst_n = 1'b0;
    #1;
    check("t5_async_valid", out_valid, 0);
    check("t5_async_count", count, 0);
    check("t5_async_data", out_data, 0);
    check("t5_async_stamp", out_stamp, 0);
    check("t5_async_full", full, 0);
    check("t5_async_ovf", overflow, 0);
    out_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("t5_after_count", count, 0);
    check("t5_after_valid", out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
